fuzz_campaign_sched: RTL and testbench
======================================

Name: fuzz_campaign_sched

Overview:
Central scheduler that runs a fuzz campaign across N_FUZZERS mutation-fuzzer instances sharing one campaign controller. It grants enable to one fuzzer at a time in round-robin order and waits for that fuzzer's ack handshake. It accumulates each fuzzer's crash/hang/mismatch/overflow flags, enforces a watchdog timeout, and keeps saturating campaign statistics for software readback.

Parameters:
N_FUZZERS, 4, number of fuzzer instances scheduled (1..16)
TIMEOUT_CYCLES, 1024, max cycles a grant may stay open without ack before it is declared timed out
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a campaign when idle
abort  in  1  pulse; terminates the running campaign
num_rounds  in  16  full passes over enabled fuzzers; 0 = finish immediately
fuzzer_mask  in  N_FUZZERS  1 = fuzzer participates; sampled at start
fuzz_enable  out  N_FUZZERS  one-hot (or zero) enable to fuzzers
fuzz_ack  in  N_FUZZERS  per-fuzzer completion pulse
fuzz_crash, fuzz_hang, fuzz_mismatch, fuzz_overflow  in  N_FUZZERS each  per-fuzzer status flags
busy  out  1  campaign in progress
done  out  1  one-cycle pulse at campaign end
aborted  out  1  sticky; set when the last campaign ended by abort; cleared on start
active_id  out  $clog2(N_FUZZERS) (min 1)  index of the granted fuzzer
round_cnt  out  16  completed rounds
crash_count, hang_count, mismatch_count, timeout_count  out  CNT_W each  saturating event counters
fail_vector  out  N_FUZZERS  sticky; bit i set if fuzzer i ever reported crash, hang or timeout
last_fail_id  out  $clog2(N_FUZZERS) (min 1)  index of the most recent failing fuzzer

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; internal mask and flag accumulators 0.
- States: IDLE, SELECT, GRANT, WAIT_ACK, SAMPLE, DONE.
- IDLE: on start && !abort, latch fuzzer_mask and num_rounds, clear the counters, round_cnt, fail_vector and aborted, and go to SELECT. busy=1 from the next cycle. If mask==0 or num_rounds==0, go straight to DONE instead. start while busy is ignored.
- SELECT: find the lowest set mask bit at or above the pointer, then GRANT. The pointer starts at 0.
- GRANT: fuzz_enable[active_id]<=1; clear the status accumulator and the watchdog; go to WAIT_ACK.
- WAIT_ACK:
  - Each cycle, OR fuzz_{crash,hang,mismatch,overflow}[active_id] into the accumulator; the ack cycle is included.
  - On fuzz_ack[active_id]: fuzz_enable<=0 on the next edge, so the fuzzer sees enable low when it returns to its IDLE. Go to SAMPLE.
  - If the watchdog reaches TIMEOUT_CYCLES-1 with no ack: fuzz_enable<=0, set the timeout flag, go to SAMPLE.
  - Acks from non-granted fuzzers are ignored.
- SAMPLE (one cycle):
  - Increment each counter whose accumulated flag is set; timeout_count increments on timeout. All counters saturate at all-ones.
  - If crash, hang or timeout occurred: set fail_vector[active_id] and update last_fail_id. Mismatch and overflow are counted but are not failures.
  - Advance the pointer to the next masked index. If it wraps past the highest set mask bit, round_cnt++. If round_cnt then equals num_rounds, go to DONE; otherwise go to SELECT.
- DONE: done=1 for one cycle, busy<=0, go to IDLE.
- abort in SELECT, GRANT, WAIT_ACK or SAMPLE: fuzz_enable<=0 on the next edge, aborted<=1, go to DONE. Counters keep the values they had before this cycle; a SAMPLE aborted in the same cycle does not update them. abort in IDLE or DONE has no effect.
- Grant-to-grant latency with immediate ack: GRANT→WAIT_ACK→SAMPLE→SELECT→GRANT = 4 cycles minimum.
- At most one fuzz_enable bit is high at any time.

Optional Feature:
STOP_ON_CRASH_EN: when defined, a SAMPLE that records crash or timeout sends the FSM to DONE after the counter updates (aborted stays 0). Without it, the campaign always runs all num_rounds.

Decomposition:
- Package fuzz_sched_pkg:
  - state enum sched_state_t
  - packed struct fuzz_status_t {crash, hang, mismatch, overflow, timeout}
  - function next_masked_idx(mask, ptr) returning index plus a wrap flag
- One sub-module fuzz_sat_counter (parameter W; inc, clr; saturating). It is instantiated four times.

Test Plan:
- N=4, mask=4'b1011, rounds=2, every fuzzer acks 10 cycles after enable with clean flags → grant order 0,1,3,0,1,3; round_cnt=2; done pulse; all counters 0.
- Fuzzer 1 pulses crash 3 cycles before ack, mask=4'b0011, rounds=1 → crash_count=1, fail_vector=4'b0010, last_fail_id=1.
- Fuzzer 2 never acks, TIMEOUT_CYCLES=16, mask=4'b0100, rounds=1 → enable drops 16 cycles after grant; timeout_count=1; fail_vector[2]=1; done.
- abort asserted mid WAIT_ACK on fuzzer 0 → fuzz_enable=0 next cycle; done pulse; aborted=1; no counter increments.
- mask=0 or num_rounds=0 at start → done 2 cycles after start; no enable ever asserted.
- STOP_ON_CRASH_EN defined, mask=4'b1111, rounds=3, fuzzer 1 crashes in round 0 → no grant after fuzzer 1; round_cnt=0; crash_count=1; aborted=0.

Source files
------------

// File: rtl/fuzz_sched_pkg.sv
// Shared types and helpers for the fuzz campaign scheduler.
package fuzz_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    GRANT,
    WAIT_ACK,
    SAMPLE,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic crash;
    logic hang;
    logic mismatch;
    logic overflow;
    logic timeout;
  } fuzz_status_t;

  typedef struct packed {
    logic [3:0] idx;
    logic       wrap;
  } next_idx_t;

  // Lowest set bit strictly above ptr; otherwise the lowest set bit overall with wrap=1.
  function automatic next_idx_t next_masked_idx(input logic [15:0] mask, input logic [3:0] ptr);
    next_idx_t  r;
    logic [3:0] first;
    first = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      if (mask[15-k]) first = 4'(15 - k);
    end
    r.idx  = first;
    r.wrap = 1'b1;
    for (int unsigned k = 0; k < 16; k++) begin
      if (mask[15-k] && ((15 - k) > 32'(ptr))) begin
        r.idx  = 4'(15 - k);
        r.wrap = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fuzz_sat_counter.sv
// Saturating event counter with synchronous clear.
module fuzz_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fuzz_campaign_sched.sv
// Round-robin fuzz campaign scheduler with watchdog and saturating statistics.
// Optional build macro STOP_ON_CRASH_EN: end the campaign on the first crash or timeout.
module fuzz_campaign_sched
  import fuzz_sched_pkg::*;
#(
  parameter int unsigned N_FUZZERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned AW            = (N_FUZZERS > 1) ? $clog2(N_FUZZERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          num_rounds,
  input  logic [N_FUZZERS-1:0] fuzzer_mask,
  output logic [N_FUZZERS-1:0] fuzz_enable,
  input  logic [N_FUZZERS-1:0] fuzz_ack,
  input  logic [N_FUZZERS-1:0] fuzz_crash,
  input  logic [N_FUZZERS-1:0] fuzz_hang,
  input  logic [N_FUZZERS-1:0] fuzz_mismatch,
  input  logic [N_FUZZERS-1:0] fuzz_overflow,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [AW-1:0]        active_id,
  output logic [15:0]          round_cnt,
  output logic [CNT_W-1:0]     crash_count,
  output logic [CNT_W-1:0]     hang_count,
  output logic [CNT_W-1:0]     mismatch_count,
  output logic [CNT_W-1:0]     timeout_count,
  output logic [N_FUZZERS-1:0] fail_vector,
  output logic [AW-1:0]        last_fail_id
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  sched_state_t         state_q, state_d;
  logic [N_FUZZERS-1:0] mask_q;
  logic [15:0]          rounds_q;
  logic [3:0]           ptr_q;
  logic [WD_W-1:0]      wdog_q;
  fuzz_status_t         status_q;

  logic [15:0] mask16;
  next_idx_t   nxt;
  logic [3:0]  sel_idx;
  logic        acked, wd_expired, running, launch, sample_ok, sample_fail, stop;

  always_comb begin
    mask16      = 16'(mask_q);
    nxt         = next_masked_idx(mask16, ptr_q);
    sel_idx     = mask16[ptr_q] ? ptr_q : nxt.idx;
    acked       = fuzz_ack[active_id];
    wd_expired  = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
    running     = (state_q == SELECT) || (state_q == GRANT) ||
                  (state_q == WAIT_ACK) || (state_q == SAMPLE);
    launch      = (state_q == IDLE) && start && !abort;
    sample_ok   = (state_q == SAMPLE) && !abort;
    sample_fail = status_q.crash || status_q.hang || status_q.timeout;
    stop        = 1'b0;
`ifdef STOP_ON_CRASH_EN
    stop        = status_q.crash || status_q.timeout;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (launch) state_d = ((fuzzer_mask == '0) || (num_rounds == '0)) ? DONE : SELECT;
      SELECT:   state_d = GRANT;
      GRANT:    state_d = WAIT_ACK;
      WAIT_ACK: if (acked || wd_expired) state_d = SAMPLE;
      SAMPLE:   state_d = ((nxt.wrap && (round_cnt + 16'd1 == rounds_q)) || stop) ? DONE : SELECT;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (running && abort) state_d = DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      fuzz_enable  <= '0;
      active_id    <= '0;
      last_fail_id <= '0;
      round_cnt    <= '0;
      fail_vector  <= '0;
      mask_q       <= '0;
      rounds_q     <= '0;
      ptr_q        <= '0;
      wdog_q       <= '0;
      status_q     <= '0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_q == DONE);
      case (state_q)
        IDLE: if (launch) begin
          mask_q      <= fuzzer_mask;
          rounds_q    <= num_rounds;
          round_cnt   <= '0;
          fail_vector <= '0;
          aborted     <= 1'b0;
          ptr_q       <= '0;
        end
        SELECT: begin
          ptr_q     <= sel_idx;
          active_id <= AW'(sel_idx);
        end
        GRANT: begin
          fuzz_enable            <= '0;
          fuzz_enable[active_id] <= 1'b1;
          status_q               <= '0;
          wdog_q                 <= '0;
        end
        WAIT_ACK: begin
          status_q.crash    <= status_q.crash    | fuzz_crash[active_id];
          status_q.hang     <= status_q.hang     | fuzz_hang[active_id];
          status_q.mismatch <= status_q.mismatch | fuzz_mismatch[active_id];
          status_q.overflow <= status_q.overflow | fuzz_overflow[active_id];
          wdog_q            <= wdog_q + WD_W'(1);
          if (acked) begin
            fuzz_enable <= '0;
          end else if (wd_expired) begin
            fuzz_enable      <= '0;
            status_q.timeout <= 1'b1;
          end
        end
        SAMPLE: if (!abort) begin
          if (sample_fail) begin
            fail_vector[active_id] <= 1'b1;
            last_fail_id           <= active_id;
          end
          ptr_q <= nxt.idx;
          if (nxt.wrap) round_cnt <= round_cnt + 16'd1;
        end
        default: ;
      endcase
      // Abort overrides whatever the running state scheduled this cycle.
      if (running && abort) begin
        fuzz_enable <= '0;
        aborted     <= 1'b1;
      end
    end
  end

  fuzz_sat_counter #(.W(CNT_W)) u_crash_cnt (
    .clk(clk), .rst_n(rst_n), .clr(launch),
    .inc(sample_ok && status_q.crash), .count(crash_count)
  );
  fuzz_sat_counter #(.W(CNT_W)) u_hang_cnt (
    .clk(clk), .rst_n(rst_n), .clr(launch),
    .inc(sample_ok && status_q.hang), .count(hang_count)
  );
  fuzz_sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk(clk), .rst_n(rst_n), .clr(launch),
    .inc(sample_ok && status_q.mismatch), .count(mismatch_count)
  );
  fuzz_sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .clk(clk), .rst_n(rst_n), .clr(launch),
    .inc(sample_ok && status_q.timeout), .count(timeout_count)
  );

endmodule

// File: tb/tb_fuzz_campaign_sched.sv
// Scoreboard bench for fuzz_campaign_sched: expected grants and end-of-campaign records are queued
// by the stimulus and checked by an independent monitor; honours STOP_ON_CRASH_EN.
module tb_fuzz_campaign_sched;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [15:0]  num_rounds = '0;
  logic [N-1:0] fuzzer_mask = '0;
  logic [N-1:0] fuzz_enable, fuzz_ack, fuzz_crash, fuzz_hang, fuzz_mismatch, fuzz_overflow;
  logic         busy, done, aborted;
  logic [1:0]   active_id, last_fail_id;
  logic [15:0]  round_cnt, crash_count, hang_count, mismatch_count, timeout_count;
  logic [N-1:0] fail_vector;

  fuzz_campaign_sched #(.N_FUZZERS(N), .TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_rounds(num_rounds), .fuzzer_mask(fuzzer_mask),
    .fuzz_enable(fuzz_enable), .fuzz_ack(fuzz_ack), .fuzz_crash(fuzz_crash),
    .fuzz_hang(fuzz_hang), .fuzz_mismatch(fuzz_mismatch), .fuzz_overflow(fuzz_overflow),
    .busy(busy), .done(done), .aborted(aborted), .active_id(active_id),
    .round_cnt(round_cnt), .crash_count(crash_count), .hang_count(hang_count),
    .mismatch_count(mismatch_count), .timeout_count(timeout_count),
    .fail_vector(fail_vector), .last_fail_id(last_fail_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0]  rnd;
    logic [15:0]  crash, hang, mism, tmo;
    logic [N-1:0] fail;
    logic [1:0]   last;
    logic         abt;
  } rec_t;

  int   grant_q[$];
  rec_t done_q[$];

  task automatic push_rec(input logic [15:0] rnd, input logic [15:0] c, input logic [15:0] h,
                          input logic [15:0] m, input logic [15:0] t, input logic [N-1:0] f,
                          input logic [1:0] l, input logic a);
    rec_t r;
    r.rnd = rnd; r.crash = c; r.hang = h; r.mism = m; r.tmo = t; r.fail = f; r.last = l; r.abt = a;
    done_q.push_back(r);
  endtask

  // Fuzzer models: ack ack_dly cycles into a grant (0 = never); one event of ev_kind
  // (0 crash, 1 hang, 2 mismatch, 3 overflow) at cycle ev_at of the ev_grant-th grant.
  int ack_dly[N];
  int ev_at[N];
  int ev_grant[N];
  int ev_kind[N];

  initial begin
    int en_cnt[N];
    int gno[N];
    logic [N-1:0] a, c, h, m, o;
    for (int i = 0; i < N; i++) begin en_cnt[i] = 0; gno[i] = 0; end
    fuzz_ack = '0; fuzz_crash = '0; fuzz_hang = '0; fuzz_mismatch = '0; fuzz_overflow = '0;
    forever begin
      @(negedge clk);
      a = '0; c = '0; h = '0; m = '0; o = '0;
      for (int i = 0; i < N; i++) begin
        if (!busy) gno[i] = 0;
        if (fuzz_enable[i]) begin
          if (en_cnt[i] == 0) gno[i]++;
          en_cnt[i]++;
          a[i] = (ack_dly[i] != 0) && (en_cnt[i] == ack_dly[i]);
          if (en_cnt[i] == ev_at[i] && gno[i] == ev_grant[i]) begin
            c[i] = (ev_kind[i] == 0);
            h[i] = (ev_kind[i] == 1);
            m[i] = (ev_kind[i] == 2);
            o[i] = (ev_kind[i] == 3);
          end
        end else begin
          en_cnt[i] = 0;
        end
      end
      fuzz_ack = a; fuzz_crash = c; fuzz_hang = h; fuzz_mismatch = m; fuzz_overflow = o;
    end
  end

  // Monitor: checks each new grant and each done pulse against the queues.
  initial begin
    logic [N-1:0] prev_en = '0;
    logic         prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fuzz_enable != '0 && prev_en == '0) begin
          chk("enable_onehot", 32'($onehot(fuzz_enable)), 32'd1);
          if (grant_q.size() == 0) begin
            chk("unexpected_grant", 32'(fuzz_enable), 32'd0);
          end else begin
            int e;
            e = grant_q.pop_front();
            chk("grant_id", 32'(fuzz_enable), 32'(1 << e));
            chk("active_id", 32'(active_id), 32'(e));
          end
        end
        if (prev_done) chk("done_width", 32'(done), 32'd0);
        if (done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            rec_t r;
            r = done_q.pop_front();
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("round_cnt", 32'(round_cnt), 32'(r.rnd));
            chk("crash_count", 32'(crash_count), 32'(r.crash));
            chk("hang_count", 32'(hang_count), 32'(r.hang));
            chk("mismatch_count", 32'(mismatch_count), 32'(r.mism));
            chk("timeout_count", 32'(timeout_count), 32'(r.tmo));
            chk("fail_vector", 32'(fail_vector), 32'(r.fail));
            chk("last_fail_id", 32'(last_fail_id), 32'(r.last));
            chk("aborted", 32'(aborted), 32'(r.abt));
          end
        end
        prev_en   = fuzz_enable;
        prev_done = done;
      end
    end
  end

  task automatic cfg_clean();
    for (int i = 0; i < N; i++) begin
      ack_dly[i] = 10; ev_at[i] = 0; ev_grant[i] = 0; ev_kind[i] = 0;
    end
  endtask

  task automatic launch(input logic [N-1:0] msk, input logic [15:0] rnds);
    @(negedge clk);
    fuzzer_mask = msk; num_rounds = rnds; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_enable(input int idx);
    int n;
    n = 0;
    while (!fuzz_enable[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!fuzz_enable[idx]) chk("enable_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int len;
    cfg_clean();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_enable", 32'(fuzz_enable), 32'd0);
    chk("rst_round", 32'(round_cnt), 32'd0);
    chk("rst_counts", 32'({crash_count | hang_count | mismatch_count | timeout_count}), 32'd0);
    chk("rst_fail", 32'({fail_vector, aborted, last_fail_id, active_id}), 32'd0);

    // Round robin over 1011, two rounds; a start mid-campaign must be ignored.
    cfg_clean();
    grant_q = '{0, 1, 3, 0, 1, 3};
    push_rec(16'd2, 0, 0, 0, 0, 4'b0000, 2'd0, 1'b0);
    launch(4'b1011, 16'd2);
    repeat (20) @(negedge clk);
    fuzzer_mask = 4'b0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);

    // Crash on fuzzer 1 three cycles before ack; mismatch on fuzzer 0 is counted, not a failure.
    cfg_clean();
    ev_at[1] = 7; ev_grant[1] = 1; ev_kind[1] = 0;
    ev_at[0] = 4; ev_grant[0] = 1; ev_kind[0] = 2;
    grant_q = '{0, 1};
    push_rec(16'd1, 16'd1, 0, 16'd1, 0, 4'b0010, 2'd1, 1'b0);
    launch(4'b0011, 16'd1);
    wait_done(cyc);

    // Hang reported in the ack cycle itself; overflow is not counted.
    cfg_clean();
    ev_at[0] = 3;  ev_grant[0] = 1; ev_kind[0] = 3;
    ev_at[2] = 10; ev_grant[2] = 1; ev_kind[2] = 1;
    grant_q = '{0, 2};
    push_rec(16'd1, 0, 16'd1, 0, 0, 4'b0100, 2'd2, 1'b0);
    launch(4'b0101, 16'd1);
    wait_done(cyc);

    // Watchdog: fuzzer 2 never acks; enable must stay high exactly 16 cycles.
    cfg_clean();
    ack_dly[2] = 0;
    grant_q = '{2};
    push_rec(16'd1, 0, 0, 0, 16'd1, 4'b0100, 2'd2, 1'b0);
    launch(4'b0100, 16'd1);
    wait_enable(2);
    len = 1;
    while (fuzz_enable[2] && len < 100) begin
      @(negedge clk);
      if (fuzz_enable[2]) len++;
    end
    chk("timeout_enable_len", 32'(len), 32'd16);
    wait_done(cyc);

    // Abort during WAIT_ACK after a crash pulse: nothing is counted.
    cfg_clean();
    ack_dly[0] = 0;
    ev_at[0] = 2; ev_grant[0] = 1; ev_kind[0] = 0;
    grant_q = '{0};
    push_rec(16'd0, 0, 0, 0, 0, 4'b0000, 2'd2, 1'b1);
    launch(4'b0001, 16'd1);
    wait_enable(0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_enable_off", 32'(fuzz_enable), 32'd0);
    wait_done(cyc);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_sticky", 32'(aborted), 32'd1);
    chk("idle_abort_busy", 32'(busy), 32'd0);

    // Empty mask and zero rounds finish without any grant.
    cfg_clean();
    push_rec(16'd0, 0, 0, 0, 0, 4'b0000, 2'd2, 1'b0);
    launch(4'b0000, 16'd3);
    wait_done(cyc);
    chk("mask0_latency", 32'(cyc), 32'd2);
    push_rec(16'd0, 0, 0, 0, 0, 4'b0000, 2'd2, 1'b0);
    launch(4'b1111, 16'd0);
    wait_done(cyc);
    chk("rounds0_latency", 32'(cyc), 32'd2);

    // Fuzzer 1 crashes in round 0 of three.
    cfg_clean();
    ev_at[1] = 5; ev_grant[1] = 1; ev_kind[1] = 0;
`ifdef STOP_ON_CRASH_EN
    grant_q = '{0, 1};
    push_rec(16'd0, 16'd1, 0, 0, 0, 4'b0010, 2'd1, 1'b0);
`else
    grant_q = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    push_rec(16'd3, 16'd1, 0, 0, 0, 4'b0010, 2'd1, 1'b0);
`endif
    launch(4'b1111, 16'd3);
    wait_done(cyc);

    chk("grant_q_drained", 32'(grant_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
